// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC and pipe controls, instruction-memory port, and the
// decode-facing instruction and counters.
interface instr_fetch_if;
   logic [15:0] pc;
   logic        stall_IM_ID;
   logic        flow_change_ID_EX;
   logic [15:0] im_addr;
   logic        im_rd_en;
   logic [15:0] im_rdata;
   logic [15:0] instr_IM_ID;
   logic        instr_vld_IM_ID;
   logic [15:0] fetch_cnt;
   logic [15:0] bubble_cnt;

   modport master (
      input  pc, stall_IM_ID, flow_change_ID_EX, im_rdata,
      output im_addr, im_rd_en, instr_IM_ID, instr_vld_IM_ID, fetch_cnt, bubble_cnt
   );

   modport slave (
      output pc, stall_IM_ID, flow_change_ID_EX, im_rdata,
      input  im_addr, im_rd_en, instr_IM_ID, instr_vld_IM_ID, fetch_cnt, bubble_cnt
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage and IM_ID boundary: drives the synchronous instruction memory,
// holds the slot across stalls, squashes the wrong-path slot and counts fetches/bubbles.
module instr_fetch #(
   parameter logic [15:0] NOP_INSTR = 16'hF000
) (
   input logic           clk,
   input logic           rst,
   instr_fetch_if.master bus
);
   logic        r_held;
   logic        r_hold_vld;
   logic        r_squash;
   logic [15:0] r_hold_instr;
   logic [15:0] r_fetch_cnt;
   logic [15:0] r_bubble_cnt;

   logic [15:0] w_instr;
   logic        w_vld;

   always_comb begin
      w_instr = bus.im_rdata;
      w_vld   = 1'b1;
      if (r_held) begin
         w_instr = r_hold_instr;
         w_vld   = r_hold_vld;
      end else if (r_squash) begin
         w_instr = NOP_INSTR;
         w_vld   = 1'b0;
      end
   end

   // Snapshot the visible slot on the first stall edge so the output no longer depends on
   // what the memory does with its read data while reads are disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_held       <= 1'b0;
         r_hold_instr <= NOP_INSTR;
         r_hold_vld   <= 1'b0;
         r_squash     <= 1'b1;
         r_fetch_cnt  <= 16'h0000;
         r_bubble_cnt <= 16'h0000;
      end else if (bus.stall_IM_ID) begin
         if (!r_held) begin
            r_hold_instr <= w_instr;
            r_hold_vld   <= w_vld;
            r_held       <= 1'b1;
         end
      end else begin
         r_held   <= 1'b0;
         r_squash <= bus.flow_change_ID_EX;
         if (w_vld) begin
            r_fetch_cnt <= r_fetch_cnt + 16'd1;
         end else if (r_bubble_cnt != 16'hFFFF) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
         end
      end
   end

   assign bus.im_addr         = bus.pc;
   assign bus.im_rd_en        = !bus.stall_IM_ID && !rst;
   assign bus.instr_IM_ID     = w_instr;
   assign bus.instr_vld_IM_ID = w_vld;
   assign bus.fetch_cnt       = r_fetch_cnt;
   assign bus.bubble_cnt      = r_bubble_cnt;
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: synchronous memory model, scoreboard of expected
// decode slots, and scenario tasks for reset, fetch, stall, squash and counter limits.
module tb_instr_fetch;
   localparam logic [15:0] NOP = 16'hF000;

   typedef struct packed {
      logic [15:0] instr;
      logic        vld;
   } slot_t;

   logic clk;
   logic rst;
   instr_fetch_if bus ();

   instr_fetch #(.NOP_INSTR(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   slot_t       exp_q[$];
   slot_t       m_cur;
   logic [15:0] m_fetch;
   logic [15:0] m_bub;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      return a * 16'h9E37 + 16'h1234;
   endfunction

   // Synchronous memory; garbage on its output whenever reads are disabled.
   always @(posedge clk) begin
      if (bus.im_rd_en) bus.im_rdata <= mem_f(bus.im_addr);
      else              bus.im_rdata <= 16'($urandom);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock: drive controls, predict the slot visible after the edge, advance the PC.
   task automatic step(input logic st, input logic fl, input logic [15:0] next_pc);
      slot_t e;
      bus.stall_IM_ID       = st;
      bus.flow_change_ID_EX = fl;
      if (st) begin
         e = m_cur;
      end else begin
         if (m_cur.vld)              m_fetch = m_fetch + 16'd1;
         else if (m_bub != 16'hFFFF) m_bub   = m_bub + 16'd1;
         e = fl ? {NOP, 1'b0} : {mem_f(bus.pc), 1'b1};
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      m_cur = e;
      if (!st) bus.pc = next_pc;
   endtask

   task automatic model_reset();
      m_cur   = {NOP, 1'b0};
      m_fetch = 16'h0000;
      m_bub   = 16'h0000;
      exp_q.delete();
   endtask

   task automatic test_reset();
      slot_t e;
      rst = 1'b1;
      bus.pc = 16'h0000;
      bus.stall_IM_ID = 1'b0;
      bus.flow_change_ID_EX = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.instr_IM_ID !== NOP || bus.instr_vld_IM_ID !== 1'b0 || bus.im_rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: got %h/%b rd_en=%b want %h/0 rd_en=0",
                  bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.im_rd_en, NOP);
      end
      n_cmp++;
      if (bus.fetch_cnt !== 16'h0 || bus.bubble_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_cnt: got %h/%h want 0000/0000", bus.fetch_cnt, bus.bubble_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.instr_IM_ID !== NOP || bus.instr_vld_IM_ID !== 1'b0 || bus.im_rd_en !== 1'b1) begin
         n_fail++;
         $display("FAIL release_first: got %h/%b rd_en=%b want %h/0 rd_en=1",
                  bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.im_rd_en, NOP);
      end
      step(1'b0, 1'b0, 16'h0001);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.instr_IM_ID !== 16'h1234 || bus.instr_vld_IM_ID !== 1'b1 || e.instr !== 16'h1234) begin
         n_fail++;
         $display("FAIL release_mem0: got %h/%b want 1234/1", bus.instr_IM_ID, bus.instr_vld_IM_ID);
      end
      n_cmp++;
      if (bus.bubble_cnt !== 16'h0001) begin
         n_fail++;
         $display("FAIL release_bubble: got %h want 0001", bus.bubble_cnt);
      end
   endtask

   task automatic test_straight();
      slot_t e;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, bus.pc + 16'd1);
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.instr_IM_ID !== e.instr || bus.instr_vld_IM_ID !== e.vld ||
             bus.im_addr !== bus.pc) begin
            n_fail++;
            $display("FAIL straight[%0d]: got %h/%b addr=%h want %h/%b addr=%h", i,
                     bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.im_addr, e.instr, e.vld, bus.pc);
         end
      end
      n_cmp++;
      if (bus.fetch_cnt !== 16'd10 || bus.fetch_cnt !== m_fetch) begin
         n_fail++;
         $display("FAIL straight_cnt: got %0d want 10", bus.fetch_cnt);
      end
   endtask

   task automatic test_stall();
      slot_t e;
      slot_t pre;
      pre = m_cur;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, bus.pc);
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.instr_IM_ID !== pre.instr || bus.instr_vld_IM_ID !== pre.vld ||
             e !== pre || bus.im_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stall[%0d]: got %h/%b rd_en=%b want %h/%b rd_en=0", i,
                     bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.im_rd_en, pre.instr, pre.vld);
         end
      end
      step(1'b0, 1'b0, bus.pc + 16'd1);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.instr_IM_ID !== e.instr || bus.instr_vld_IM_ID !== e.vld) begin
         n_fail++;
         $display("FAIL stall_release: got %h/%b want %h/%b",
                  bus.instr_IM_ID, bus.instr_vld_IM_ID, e.instr, e.vld);
      end
   endtask

   task automatic test_branch();
      slot_t       e;
      logic [15:0] bub0;
      bub0 = bus.bubble_cnt;
      step(1'b0, 1'b1, 16'h0040);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.instr_IM_ID !== NOP || bus.instr_vld_IM_ID !== 1'b0 || e.vld !== 1'b0) begin
         n_fail++;
         $display("FAIL branch_nop: got %h/%b want %h/0", bus.instr_IM_ID, bus.instr_vld_IM_ID, NOP);
      end
      step(1'b0, 1'b0, 16'h0041);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.instr_IM_ID !== mem_f(16'h0040) || bus.instr_vld_IM_ID !== 1'b1) begin
         n_fail++;
         $display("FAIL branch_target: got %h/%b want %h/1",
                  bus.instr_IM_ID, bus.instr_vld_IM_ID, mem_f(16'h0040));
      end
      n_cmp++;
      if (bus.bubble_cnt !== bub0 + 16'd1 || bus.fetch_cnt !== m_fetch) begin
         n_fail++;
         $display("FAIL branch_cnt: got %h/%h want %h/%h",
                  bus.bubble_cnt, bus.fetch_cnt, bub0 + 16'd1, m_fetch);
      end
   endtask

   task automatic test_flow_in_stall();
      slot_t       e;
      logic [15:0] f0;
      logic [15:0] b0;
      f0 = bus.fetch_cnt;
      b0 = bus.bubble_cnt;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, bus.pc);
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.instr_IM_ID !== e.instr || bus.instr_vld_IM_ID !== e.vld ||
             bus.fetch_cnt !== f0 || bus.bubble_cnt !== b0) begin
            n_fail++;
            $display("FAIL flow_in_stall[%0d]: got %h/%b cnt %h/%h want %h/%b cnt %h/%h", i,
                     bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.fetch_cnt, bus.bubble_cnt,
                     e.instr, e.vld, f0, b0);
         end
      end
      step(1'b0, 1'b0, bus.pc + 16'd1);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.instr_IM_ID !== e.instr || bus.instr_vld_IM_ID !== 1'b1 || e.vld !== 1'b1) begin
         n_fail++;
         $display("FAIL flow_in_stall_release: got %h/%b want %h/1",
                  bus.instr_IM_ID, bus.instr_vld_IM_ID, e.instr);
      end
   endtask

   task automatic test_squash_stall();
      slot_t       e;
      logic [15:0] b0;
      b0 = bus.bubble_cnt;
      step(1'b0, 1'b1, 16'h0080);
      e = exp_q.pop_front();
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b0, 16'h0080);
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.instr_IM_ID !== NOP || bus.instr_vld_IM_ID !== 1'b0 || bus.bubble_cnt !== b0) begin
            n_fail++;
            $display("FAIL squash_hold[%0d]: got %h/%b bub=%h want %h/0 bub=%h", i,
                     bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.bubble_cnt, NOP, b0);
         end
      end
      step(1'b0, 1'b0, 16'h0081);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.instr_IM_ID !== mem_f(16'h0080) || bus.instr_vld_IM_ID !== 1'b1 ||
          bus.bubble_cnt !== b0 + 16'd1) begin
         n_fail++;
         $display("FAIL squash_release: got %h/%b bub=%h want %h/1 bub=%h", bus.instr_IM_ID,
                  bus.instr_vld_IM_ID, bus.bubble_cnt, mem_f(16'h0080), b0 + 16'd1);
      end
   endtask

   task automatic test_saturation();
      slot_t e;
      force dut.r_bubble_cnt = 16'hFFFD;
      force dut.r_fetch_cnt  = 16'hFFFE;
      #1;
      release dut.r_bubble_cnt;
      release dut.r_fetch_cnt;
      m_bub   = 16'hFFFD;
      m_fetch = 16'hFFFE;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, (i < 4), bus.pc + 16'd1);
         e = exp_q.pop_front();
         n_cmp++;
         if (bus.instr_IM_ID !== e.instr || bus.instr_vld_IM_ID !== e.vld ||
             bus.fetch_cnt !== m_fetch || bus.bubble_cnt !== m_bub) begin
            n_fail++;
            $display("FAIL limits[%0d]: got %h/%b cnt %h/%h want %h/%b cnt %h/%h", i,
                     bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.fetch_cnt, bus.bubble_cnt,
                     e.instr, e.vld, m_fetch, m_bub);
         end
      end
      n_cmp++;
      if (bus.bubble_cnt !== 16'hFFFF || bus.fetch_cnt > 16'h0010) begin
         n_fail++;
         $display("FAIL limits_final: bub=%h fetch=%h want bub=FFFF fetch wrapped",
                  bus.bubble_cnt, bus.fetch_cnt);
      end
   endtask

   task automatic test_async_reset();
      slot_t e;
      step(1'b0, 1'b0, bus.pc + 16'd1);
      e = exp_q.pop_front();
      step(1'b1, 1'b1, bus.pc);
      e = exp_q.pop_front();
      #3;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.instr_IM_ID !== NOP || bus.instr_vld_IM_ID !== 1'b0 || bus.im_rd_en !== 1'b0 ||
          bus.fetch_cnt !== 16'h0 || bus.bubble_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL async_rst: got %h/%b rd_en=%b cnt %h/%h want %h/0 rd_en=0 cnt 0/0",
                  bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.im_rd_en, bus.fetch_cnt,
                  bus.bubble_cnt, NOP);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.fetch_cnt !== 16'h0 || bus.bubble_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL async_rst_edge: got %h/%h want 0000/0000", bus.fetch_cnt, bus.bubble_cnt);
      end
      @(negedge clk);
      bus.stall_IM_ID = 1'b0;
      bus.flow_change_ID_EX = 1'b0;
      bus.pc = 16'h0010;
      model_reset();
      rst = 1'b0;
      step(1'b0, 1'b0, 16'h0011);
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.instr_IM_ID !== mem_f(16'h0010) || bus.instr_vld_IM_ID !== 1'b1 ||
          bus.bubble_cnt !== 16'h0001 || bus.fetch_cnt !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_rst_resume: got %h/%b cnt %h/%h want %h/1 cnt 0000/0001",
                  bus.instr_IM_ID, bus.instr_vld_IM_ID, bus.fetch_cnt, bus.bubble_cnt,
                  mem_f(16'h0010));
      end
   endtask

   initial begin
      test_reset();
      test_straight();
      test_stall();
      test_branch();
      test_flow_in_stall();
      test_squash_stall();
      test_saturation();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage. It sits directly downstream of the program-counter register and forms the IM_ID pipeline boundary. The block drives the synchronous instruction memory from `pc`, presents the fetched instruction to decode as `instr_IM_ID`, and holds that instruction steady across `stall_IM_ID`. It squashes the wrong-path slot after a taken branch or jump (`flow_change_ID_EX`) and keeps fetch/bubble performance counters.

## Interface
- `NOP_INSTR`, default 16'hF000: encoding injected into decode for squashed or invalid slots.
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pc`  in  16: current PC from the PC register; this is the fetch address.
- `stall_IM_ID`  in  1: pipe stall; the same signal that freezes the PC.
- `flow_change_ID_EX`  in  1: taken branch or jump resolved in EX.
- `im_addr`  out  16: instruction-memory address; combinational, equal to `pc`.
- `im_rd_en`  out  1: memory read enable; equals `!stall_IM_ID && !rst`.
- `im_rdata`  in  16: memory read data, valid one cycle after the `im_addr`/`im_rd_en` sample.
- `instr_IM_ID`  out  16: instruction presented to decode.
- `instr_vld_IM_ID`  out  1: high when `instr_IM_ID` is a real, non-squashed instruction.
- `fetch_cnt`  out  16: count of valid instructions accepted by decode; wraps.
- `bubble_cnt`  out  16: count of squashed slots accepted by decode; saturates at 16'hFFFF.

## Operation
- An "accept" is any rising edge with `stall_IM_ID`=0. Decode consumes `instr_IM_ID` and `instr_vld_IM_ID` on accept edges.
- **Internal state**
  - `held` (1b), `hold_instr` (16b), `hold_vld` (1b).
  - `squash` (1b).
  - The two counters.
- **Output select**
  - If `held`=1: output `hold_instr` / `hold_vld`.
  - Else if `squash`=1: output `NOP_INSTR` / 0.
  - Else: output `im_rdata` / 1.
- **Stall hold**
  - Edge with stall=1 and `held`=0: capture the current outputs into `hold_instr` / `hold_vld`, then set `held`=1.
  - Edge with stall=1 and `held`=1: no change.
  - Edge with stall=0: clear `held`=0.
  - The output therefore does not depend on the memory's output-hold behaviour during stalls.
- **Squash**
  - Edge with stall=0 and `flow_change_ID_EX`=1: set `squash`=1. The slot fetched from the old `pc` arrives next cycle and is wrong-path.
  - Edge with stall=0 and `flow_change_ID_EX`=0: clear `squash`=0.
  - Edges with stall=1 leave `squash` unchanged, and `flow_change_ID_EX` is ignored. This matches the PC, which does not redirect while stalled.
- **Counters**, updated on accept edges only:
  - Output valid: `fetch_cnt` +1, modulo 2^16.
  - Output invalid: `bubble_cnt` +1, saturating; stays at 16'hFFFF once reached.
- **Reset values**
  - `held`=0, `hold_instr`=`NOP_INSTR`, `hold_vld`=0.
  - `squash`=1, because memory data in the first cycle after reset is garbage.
  - Both counters 0.
  - Resulting outputs during and just after reset: `instr_IM_ID`=`NOP_INSTR`, `instr_vld_IM_ID`=0, `im_rd_en`=0 while `rst` is high.

## Timing
- Fetch latency: `im_addr` = P on edge k gives `instr_IM_ID` = mem[P] in the cycle after edge k (one cycle), absent squash.
- Flow change at accept edge k:
  - The slot visible after edge k is squashed (NOP, vld=0).
  - The target instruction appears after edge k+1.
  - Exactly one bubble is produced; squashing the decode-resident slot is the ID_EX stage's job.
- Stall of n cycles starting at edge k:
  - The output is frozen at its pre-edge-k value for n cycles.
  - On the first cycle after the stall ends, the output shows `im_rdata` for the unchanged `pc`.
- Stall asserted while `squash`=1: the NOP slot is held and `squash` persists. On release, NOP is accepted once and counted once in `bubble_cnt`.
- Asynchronous `rst` mid-stall or mid-squash: all state returns to reset values immediately; no counter increments on that edge.

## Test plan
- **Reset release:** deassert `rst` with mem[0]=16'h1234 and no stall.
  - First cycle: NOP, vld=0.
  - Next cycle: 16'h1234, vld=1.
  - `bubble_cnt`=1 after the first accept.
- **Straight-line fetch:** 10 sequential accepts → `instr_IM_ID` = mem[pc-1] each cycle and `fetch_cnt`=10.
- **Stall hold:** stall for 3 cycles while the memory model drives random `im_rdata` → output stays at the pre-stall value for 3 cycles, and `im_rd_en`=0 throughout.
- **Taken branch:** pulse `flow_change_ID_EX` with the PC redirected to 16'h0040 → exactly one NOP/vld=0 slot, then mem[16'h0040]; `bubble_cnt` +1.
- **Flow change during stall:** assert `flow_change_ID_EX` with stall=1 → no squash and no counter change.
- **Squash overlapped with stall:** a flow change followed by a 2-cycle stall → NOP held for 2 cycles and `bubble_cnt` increments once.
- **Saturation, wrap and reset:**
  - Preload `bubble_cnt` near 16'hFFFF and force squashes → it stops at 16'hFFFF.
  - `fetch_cnt` wraps from 16'hFFFF to 0.
  - Asynchronous `rst` mid-stall clears everything.
